// File: rtl/mito_pool_pkg.sv
// Shared types for the pool engine: layer-mode encodings and the frame FSM states.
package mito_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    CONVOL = 2'b01,
    FULLY  = 2'b10,
    POOL   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

endpackage

// File: rtl/pool_linebuf.sv
// Half-row line buffer: holds the even-row pair maxima until the odd row arrives.
module pool_linebuf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool_engine.sv
// Streaming layer post-processor: pass-through with optional ReLU, or 2x2 stride-2
// signed max pooling across CH parallel lanes, with a single registered output stage.
module pool_engine
  import mito_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int MAX_W  = 32,
  parameter int MAX_H  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    cfg_mode,
  input  logic                          cfg_relu,
  input  logic [$clog2(MAX_W+1)-1:0]    cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]    cfg_height,
  input  logic [CH*DATA_W-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CH*DATA_W-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int WW       = $clog2(MAX_W+1);
  localparam int HW       = $clog2(MAX_H+1);
  localparam int DW       = CH*DATA_W;
  localparam int LB_DEPTH = MAX_W/2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic            relu_q, relu_d;
  logic [WW-1:0]   width_q, width_d, col_q, col_d;
  logic [HW-1:0]   height_q, height_d, row_q, row_d;
  logic [DW-1:0]   hold_q, hold_d, out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  logic            beat, last_col, last_row, pool_mode, produce, lb_we;
  logic [AW-1:0]   lb_addr;
  logic [DW-1:0]   lb_rdata, lb_wdata, pool_res, pass_res;

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign beat      = in_valid && in_ready;
  assign last_col  = (col_q == width_q - WW'(1));
  assign last_row  = (row_q == height_q - HW'(1));
  assign pool_mode = (mode_q == POOL);
  // Outputs only close a 2x2 window; odd trailing rows/cols never reach this case.
  assign produce   = pool_mode ? (row_q[0] && col_q[0]) : 1'b1;
  assign lb_we     = beat && pool_mode && !row_q[0] && col_q[0];
  assign lb_addr   = AW'(col_q >> 1);

  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  pool_linebuf #(
    .DEPTH (LB_DEPTH),
    .AW    (AW),
    .W     (DW)
  ) u_linebuf (
    .clk_i   (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (lb_wdata),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic signed [DATA_W-1:0] pix, hld, lb, m2, m3;
    assign pix = in_data[k*DATA_W +: DATA_W];
    assign hld = hold_q[k*DATA_W +: DATA_W];
    assign lb  = lb_rdata[k*DATA_W +: DATA_W];
    assign m2  = (pix > hld) ? pix : hld;
    assign m3  = (lb > m2) ? lb : m2;
    assign lb_wdata[k*DATA_W +: DATA_W] = m2;
    assign pool_res[k*DATA_W +: DATA_W] = (relu_q && m3[DATA_W-1])  ? '0 : m3;
    assign pass_res[k*DATA_W +: DATA_W] = (relu_q && pix[DATA_W-1]) ? '0 : pix;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (beat && last_col && last_row) state_d = DRAIN;
      DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    relu_d      = relu_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (state_q == IDLE && start) begin
      mode_d   = mode_e'(cfg_mode);
      relu_d   = cfg_relu;
      width_d  = cfg_width;
      height_d = cfg_height;
      col_d    = '0;
      row_d    = '0;
    end

    if (out_ready) out_valid_d = 1'b0;

    if (beat) begin
      if (pool_mode && !col_q[0]) hold_d = in_data;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + HW'(1);
      end else begin
        col_d = col_q + WW'(1);
      end
      if (produce) begin
        out_valid_d = 1'b1;
        out_data_d  = pool_mode ? pool_res : pass_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= PASS;
      relu_q      <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      relu_q      <= relu_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Self-checking bench for pool_engine: vector table, directed corner sequences and
// randomized frames scored against a window-level reference model.
module tb_pool_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_relu, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [1:0]  cfg_mode;
  logic [5:0]  cfg_width, cfg_height;
  logic [31:0] in_data, out_data;

  always #5 clk = ~clk;

  pool_engine #(.DATA_W(8), .CH(4), .MAX_W(32), .MAX_H(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_mode   (cfg_mode),
    .cfg_relu   (cfg_relu),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        relu;
    int          w;
    int          h;
    logic [31:0] px [4];
    int          n_out;
    logic [31:0] ex;
  } vec_t;

  vec_t        vec_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pix [1024];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] relu_w(input logic [31:0] v, input logic en);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < 4; k++) if (en && v[k*8+7]) r[k*8 +: 8] = 8'h00;
    return r;
  endfunction

  task automatic build_expected(input logic [1:0] mode, input logic relu, input int w, input int h);
    exp_q.delete();
    if (mode != 2'b11) begin
      for (int i = 0; i < w*h; i++) exp_q.push_back(relu_w(pix[i], relu));
    end else begin
      for (int r = 0; r < h/2; r++) begin
        for (int c = 0; c < w/2; c++) begin
          logic [31:0] o;
          o = '0;
          for (int k = 0; k < 4; k++) begin
            int best;
            best = -1000;
            for (int dr = 0; dr < 2; dr++) begin
              for (int dc = 0; dc < 2; dc++) begin
                logic [31:0] p;
                int v;
                p = pix[(2*r+dr)*w + 2*c + dc];
                v = $signed(p[k*8 +: 8]);
                if (v > best) best = v;
              end
            end
            o[k*8 +: 8] = best[7:0];
          end
          exp_q.push_back(relu_w(o, relu));
        end
      end
    end
  endtask

  task automatic add_vec(input logic [1:0] m, input logic rl, input int w, input int h,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input int n, input logic [31:0] e);
    vec_t v;
    v.mode = m; v.relu = rl; v.w = w; v.h = h;
    v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
    v.n_out = n; v.ex = e;
    vec_q.push_back(v);
  endtask

  // Runs one frame from start to done; exp_q must be loaded unless use_model is set.
  task automatic run_frame(input string tag, input logic [1:0] mode, input logic relu,
                           input int w, input int h, input int vpct, input int rpct,
                           input int stall_first, input bit noise, input bit use_model);
    int idx, cyc, dones, last_acc, done_cyc, stall_left;
    bit finished, stalled_once;
    int acc_q [$];
    if (use_model) build_expected(mode, relu, w, h);
    got_q.delete();
    @(negedge clk);
    start = 1'b1; cfg_mode = mode; cfg_relu = relu;
    cfg_width = 6'(w); cfg_height = 6'(h); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    idx = 0; cyc = 0; dones = 0; finished = 0; stall_left = 0; stalled_once = 0;
    last_acc = 0; done_cyc = 0;
    while (!finished && cyc < 4000) begin
      in_valid  = (idx < w*h) && ($urandom_range(99) < vpct);
      in_data   = in_valid ? pix[idx] : $urandom;
      out_ready = ($urandom_range(99) < rpct);
      if (noise) begin
        start      = ($urandom_range(3) == 0);
        cfg_mode   = 2'($urandom);
        cfg_relu   = 1'($urandom);
        cfg_width  = 6'($urandom_range(1, 32));
        cfg_height = 6'($urandom_range(1, 32));
      end
      #1;
      if (stall_first > 0 && !stalled_once && out_valid) begin
        stalled_once = 1;
        stall_left   = stall_first;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        #1;
        check({tag, " stall data"}, out_data, exp_q[0]);
        check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        stall_left--;
      end
      if (in_valid && in_ready) begin
        idx++;
        last_acc = cyc;
        if (mode != 2'b11) acc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (mode != 2'b11 && acc_q.size() > 0) begin
          int a;
          a = acc_q.pop_front();
          if (rpct == 100 && stall_first == 0) check({tag, " latency"}, cyc, a + 1);
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check({tag, " done seen"}, 32'(finished), 32'd1);
    check({tag, " beats consumed"}, idx, w*h);
    check({tag, " output count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, " output"}, got_q[i], exp_q[i]);
    if (rpct == 100 && stall_first == 0)
      check({tag, " done latency"}, done_cyc, last_acc + 1);
    #1;
    check({tag, " done one-shot"}, 32'(done), 32'd0);
    check({tag, " idle after done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int rst_dones;
    rst_n = 1'b0; start = 1'b0; cfg_mode = '0; cfg_relu = 1'b0; cfg_width = '0; cfg_height = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    add_vec(2'b00, 1'b0, 1, 1, 32'h807F01FF, 0, 0, 0, 1, 32'h807F01FF);
    add_vec(2'b01, 1'b1, 1, 1, 32'h7F8007FB, 0, 0, 0, 1, 32'h7F000700);
    add_vec(2'b10, 1'b1, 1, 1, 32'hFF008001, 0, 0, 0, 1, 32'h00000001);
    add_vec(2'b11, 1'b0, 2, 2, 32'hFDFDFDFD, 32'hFFFFFFFF, 32'hF8F8F8F8, 32'hFEFEFEFE, 1, 32'hFFFFFFFF);
    add_vec(2'b11, 1'b1, 2, 2, 32'hFDFDFDFD, 32'hFFFFFFFF, 32'hF8F8F8F8, 32'hFEFEFEFE, 1, 32'h00000000);
    add_vec(2'b11, 1'b0, 2, 2, 32'h01807FFE, 32'h028100FF, 32'h009010FD, 32'hFF852080, 1, 32'h02907FFF);
    add_vec(2'b11, 1'b0, 1, 2, 32'h11111111, 32'h22222222, 0, 0, 0, 32'h0);
    add_vec(2'b11, 1'b0, 2, 1, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, 0, 0, 32'h0);

    foreach (vec_q[i]) begin
      for (int j = 0; j < 4; j++) pix[j] = vec_q[i].px[j];
      exp_q.delete();
      if (vec_q[i].n_out > 0) exp_q.push_back(vec_q[i].ex);
      run_frame($sformatf("vec%0d", i), vec_q[i].mode, vec_q[i].relu, vec_q[i].w, vec_q[i].h,
                100, 100, 0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) pix[i] = {4{8'(i)}};
    exp_q = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
    run_frame("pool4x4", 2'b11, 1'b0, 4, 4, 100, 100, 0, 1'b0, 1'b0);
    exp_q = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
    run_frame("pool4x4 stall", 2'b11, 1'b0, 4, 4, 100, 100, 3, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) pix[i] = {4{8'(i + 1)}};
    exp_q = '{32'h05050505};
    run_frame("pool3x3", 2'b11, 1'b0, 3, 3, 100, 100, 0, 1'b0, 1'b0);

    pix[0] = {4{8'hFB}}; pix[1] = {4{8'h07}}; pix[2] = {4{8'h80}}; pix[3] = {4{8'h7F}};
    exp_q = '{32'h00000000, 32'h07070707, 32'h00000000, 32'h7F7F7F7F};
    run_frame("convol relu", 2'b01, 1'b1, 4, 1, 100, 100, 0, 1'b0, 1'b0);

    // Abort a 4x4 pool frame after six accepted beats.
    for (int i = 0; i < 16; i++) pix[i] = {4{8'(i)}};
    @(negedge clk);
    start = 1'b1; cfg_mode = 2'b11; cfg_relu = 1'b0; cfg_width = 6'd4; cfg_height = 6'd4;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = pix[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", out_data, 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rst_dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (done) rst_dones++;
    end
    check("midrst no done", rst_dones, 0);
    exp_q = '{32'h05050505, 32'h07070707, 32'h0D0D0D0D, 32'h0F0F0F0F};
    run_frame("post-reset pool4x4", 2'b11, 1'b0, 4, 4, 100, 100, 0, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      logic [1:0] m;
      logic       rl;
      int         w, h;
      m  = 2'($urandom_range(3));
      rl = 1'($urandom);
      w  = $urandom_range(1, 8);
      h  = $urandom_range(1, 6);
      for (int i = 0; i < w*h; i++) pix[i] = $urandom;
      run_frame($sformatf("rand%0d", f), m, rl, w, h, $urandom_range(50, 100),
                $urandom_range(40, 100), 0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
